// File: rtl/subbytes_seq.sv
// Iterative AES SubBytes: LANES sbox instances sweep the 16 state bytes, one slice per cycle.
// Byte 0 sits at [127:120]. Slices are processed in byte order, starting from the MSB end.
module subbytes_seq #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] out_data_o,
  output logic         busy_o
);

  localparam int NCYC = 16 / LANES;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NCYC - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[11'd2047 - {x, 3'b000} -: 8];
  endfunction

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [127:0]   data_q, data_d;
  logic [127:0]   sub_data;
  logic [7:0]     byte_q   [16];
  logic [7:0]     lane_out [LANES];
  logic           accept;

  for (genvar gi = 0; gi < 16; gi++) begin : g_bytes
    assign byte_q[gi] = data_q[127 - 8*gi -: 8];
  end

  // Each lane reads the byte it owns in the current slice through a 16:1 byte mux.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lanes
    logic [3:0] pos;
    assign pos          = 4'(int'(cnt_q) * LANES + gi);
    assign lane_out[gi] = sbox(byte_q[pos]);
  end

  for (genvar gi = 0; gi < 16; gi++) begin : g_merge
    assign sub_data[127 - 8*gi -: 8] =
      (CW'(gi / LANES) == cnt_q) ? lane_out[gi % LANES] : byte_q[gi];
  end

  assign in_ready_o  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready_i);
  assign accept      = in_valid_i && in_ready_o;
  assign out_valid_o = (state_q == S_DONE);
  assign busy_o      = (state_q == S_RUN);
  assign out_data_o  = data_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    case (state_q)
      S_RUN: begin
        data_d = sub_data;
        if (cnt_q == CNT_LAST) state_d = S_DONE;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      S_DONE: begin
        if (out_ready_i && !in_valid_i) state_d = S_IDLE;
      end
      default: ;
    endcase
    // A new block may arrive in IDLE or on the same edge a finished block leaves DONE.
    if (accept) begin
      data_d  = in_data_i;
      cnt_d   = '0;
      state_d = S_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

endmodule
